// File: rtl/mem_stage_if.sv
// Data-memory request/grant/response bus between the MEM stage and data memory.
// Latency: none, this is wiring only.
// Backpressure: the master holds req until gnt, then waits for rvalid.
interface mem_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mem_stage.sv
// RV32I memory-access stage: drives loads/stores onto the dmem bus and fills MEM/WB.
// Latency: one edge for non-memory ops; memory ops add (cycles to gnt + cycles to rvalid).
// Backpressure: stall holds Execute and earlier while an aligned access is outstanding.
module mem_stage (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         ex_result_src,
    input  logic               ex_mem_write,
    input  logic               ex_reg_write,
    input  logic [2:0]         ex_funct3,
    input  logic [4:0]         ex_rd,
    input  logic [31:0]        ex_alu_result,
    input  logic [31:0]        ex_write_data,
    input  logic [31:0]        ex_pc_plus4,
    output logic               stall,
    mem_stage_if.master        dmem,
    output logic               misaligned,
    output logic               wb_reg_write,
    output logic [1:0]         wb_result_src,
    output logic [4:0]         wb_rd,
    output logic [31:0]        wb_alu_result,
    output logic [31:0]        wb_read_data,
    output logic [31:0]        wb_pc_plus4
);

    typedef logic [31:0] data_t;
    typedef logic [31:0] addr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic       mem_op;
    logic       is_load;
    logic       is_byte;
    logic       is_half;
    logic       is_word;
    logic [1:0] offset;
    logic       mis_now;
    logic       go;
    logic       done;
    logic       req_int;
    logic       stall_int;
    logic [3:0] be;
    data_t      wdata;
    data_t      shifted;
    data_t      load_ext;
    addr_t      word_addr;

    // Decode access size/sign, alignment, lane mask and store data.
    always_comb begin
        mem_op    = ex_mem_write | (ex_result_src == 2'b01);
        is_load   = (ex_result_src == 2'b01) & ~ex_mem_write;
        is_byte   = (ex_funct3[1:0] == 2'b00);
        is_half   = (ex_funct3[1:0] == 2'b01);
        // funct3 values that are neither byte nor half fall back to word.
        is_word   = ~is_byte & ~is_half;
        offset    = ex_alu_result[1:0];
        mis_now   = mem_op & ((is_half & offset[0]) | (is_word & (offset != 2'b00)));
        go        = mem_op & ~mis_now;
        word_addr = {ex_alu_result[31:2], 2'b00};

        be    = 4'b1111;
        wdata = ex_write_data;
        if (is_byte) begin
            be    = 4'b0001 << offset;
            wdata = {4{ex_write_data[7:0]}};
        end else if (is_half) begin
            be    = 4'b0011 << offset;
            wdata = {2{ex_write_data[15:0]}};
        end

        // Bring the addressed byte/half down to bit 0, then extend.
        shifted  = dmem.rdata >> {offset, 3'b000};
        load_ext = shifted;
        if (is_byte) begin
            load_ext = ex_funct3[2] ? {24'h0, shifted[7:0]}
                                    : {{24{shifted[7]}}, shifted[7:0]};
        end else if (is_half) begin
            load_ext = ex_funct3[2] ? {16'h0, shifted[15:0]}
                                    : {{16{shifted[15]}}, shifted[15:0]};
        end
    end

    // Bus FSM next state and request; rvalid only matters in RESP.
    always_comb begin
        state_nxt = state;
        req_int   = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (go) begin
                    req_int   = 1'b1;
                    state_nxt = dmem.gnt ? RESP : REQ;
                end
            end
            REQ: begin
                req_int = 1'b1;
                if (dmem.gnt) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (dmem.rvalid) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        stall_int = go & ~done;
    end

    // Reset masks req/stall combinationally so upstream is free during reset.
    assign stall      = reset & stall_int;
    assign dmem.req   = reset & req_int;
    assign dmem.we    = ex_mem_write;
    assign dmem.addr  = word_addr;
    assign dmem.be    = be;
    assign dmem.wdata = wdata;

    // FSM state register; reset abandons any outstanding transaction.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // MEM/WB register: bubble while stalled or on a dropped misaligned access.
    always_ff @(posedge clk) begin
        if (!reset || stall_int || mis_now) begin
            wb_reg_write  <= 1'b0;
            wb_result_src <= 2'b00;
            wb_rd         <= 5'd0;
            wb_alu_result <= 32'h0;
            wb_read_data  <= 32'h0;
            wb_pc_plus4   <= 32'h0;
        end else begin
            wb_reg_write  <= ex_reg_write;
            wb_result_src <= ex_result_src;
            wb_rd         <= ex_rd;
            wb_alu_result <= ex_alu_result;
            wb_read_data  <= is_load ? load_ext : 32'h0;
            wb_pc_plus4   <= ex_pc_plus4;
        end
    end

    // One-cycle pulse flagging a misaligned access that was dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            misaligned <= 1'b0;
        end else begin
            misaligned <= mis_now;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage with a scoreboard of expected MEM/WB contents.
// Each op is driven on the falling edge; the bench plays the memory with programmable gnt/rvalid delays.
// Outputs are sampled 1 time unit after the falling edge or after the rising edge.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  ex_result_src;
    logic        ex_mem_write;
    logic        ex_reg_write;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_rd;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_write_data;
    logic [31:0] ex_pc_plus4;
    logic        stall;
    logic        misaligned;
    logic        wb_reg_write;
    logic [1:0]  wb_result_src;
    logic [4:0]  wb_rd;
    logic [31:0] wb_alu_result;
    logic [31:0] wb_read_data;
    logic [31:0] wb_pc_plus4;

    always #5 clk = ~clk;

    mem_stage_if dmem ();

    mem_stage dut (
        .clk           (clk),
        .reset         (reset),
        .ex_result_src (ex_result_src),
        .ex_mem_write  (ex_mem_write),
        .ex_reg_write  (ex_reg_write),
        .ex_funct3     (ex_funct3),
        .ex_rd         (ex_rd),
        .ex_alu_result (ex_alu_result),
        .ex_write_data (ex_write_data),
        .ex_pc_plus4   (ex_pc_plus4),
        .stall         (stall),
        .dmem          (dmem),
        .misaligned    (misaligned),
        .wb_reg_write  (wb_reg_write),
        .wb_result_src (wb_result_src),
        .wb_rd         (wb_rd),
        .wb_alu_result (wb_alu_result),
        .wb_read_data  (wb_read_data),
        .wb_pc_plus4   (wb_pc_plus4)
    );

    typedef struct packed {
        logic        rw;
        logic [1:0]  rs;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] rdat;
        logic [31:0] pc;
    } wb_t;

    wb_t sb[$];
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] rs, input logic mw, input logic rw, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] wd);
        ex_result_src = rs;
        ex_mem_write  = mw;
        ex_reg_write  = rw;
        ex_funct3     = f3;
        ex_rd         = rd;
        ex_alu_result = alu;
        ex_write_data = wd;
        ex_pc_plus4   = alu + 32'h1000;
    endtask

    // Drive one op, act as memory, and compare the MEM/WB result popped from the scoreboard.
    task automatic issue(input string tag, input logic [1:0] rs, input logic mw, input logic rw,
                         input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [31:0] rdat, input int gdly, input int rdly,
                         input logic exp_req, input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                         input int exp_stalls, input logic exp_mis, input logic [31:0] exp_rdata);
        int   cnt;
        int   stalls;
        logic ph;
        logic done;
        wb_t  e;
        drive(rs, mw, rw, f3, rd, alu, wd);
        if (exp_mis) e = '0;
        else         e = '{rw, rs, rd, alu, exp_rdata, alu + 32'h1000};
        sb.push_back(e);
        cnt = 0; stalls = 0; ph = 1'b0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            dmem.gnt    = exp_req && !ph && (cnt == gdly);
            dmem.rvalid = ph && (cnt == rdly);
            dmem.rdata  = dmem.rvalid ? rdat : 32'hA5A5_A5A5;
            #1;
            if (c == 0) begin
                chk({tag, "_req"}, 32'(dmem.req), 32'(exp_req));
                if (exp_req) begin
                    chk({tag, "_addr"}, dmem.addr, {alu[31:2], 2'b00});
                    chk({tag, "_be"}, 32'(dmem.be), 32'(exp_be));
                    chk({tag, "_we"}, 32'(dmem.we), 32'(mw));
                    if (mw) chk({tag, "_wdata"}, dmem.wdata, exp_wdata);
                end
            end else begin
                chk({tag, "_bubble"}, 32'(wb_reg_write), 32'd0);
                if (!ph) chk({tag, "_req_hold"}, 32'(dmem.req), 32'd1);
            end
            if (!stall) begin
                done = 1'b1;
            end else begin
                stalls++;
                @(posedge clk);
                if (dmem.gnt) begin ph = 1'b1; cnt = 1; end
                else cnt++;
                @(negedge clk);
            end
        end
        if (!done) chk({tag, "_timeout"}, 32'd0, 32'd1);
        chk({tag, "_stalls"}, 32'(stalls), 32'(exp_stalls));
        @(posedge clk);
        #1;
        dmem.gnt    = 1'b0;
        dmem.rvalid = 1'b0;
        e = sb.pop_front();
        chk({tag, "_wb_reg_write"}, 32'(wb_reg_write), 32'(e.rw));
        chk({tag, "_wb_result_src"}, 32'(wb_result_src), 32'(e.rs));
        chk({tag, "_wb_rd"}, 32'(wb_rd), 32'(e.rd));
        chk({tag, "_wb_alu"}, wb_alu_result, e.alu);
        chk({tag, "_wb_rdata"}, wb_read_data, e.rdat);
        chk({tag, "_wb_pc"}, wb_pc_plus4, e.pc);
        chk({tag, "_misaligned"}, 32'(misaligned), 32'(exp_mis));
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b0;
        dmem.gnt    = 1'b0;
        dmem.rvalid = 1'b0;
        dmem.rdata  = 32'h0;
        drive(2'b00, 1'b0, 1'b0, 3'b000, 5'd0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_req", 32'(dmem.req), 32'd0);
        chk("rst_misaligned", 32'(misaligned), 32'd0);
        reset = 1'b1;
        #1;
        chk("rst_wb_reg_write", 32'(wb_reg_write), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_alu", wb_alu_result, 32'h0);
        chk("rst_wb_rdata", wb_read_data, 32'h0);
        chk("rst_wb_pc", wb_pc_plus4, 32'h0);
        @(negedge clk);

        //    tag      rs     mw    rw    f3      rd     alu           wd            rdat          g  r  req   be       wdata         st mis  exp_rdata
        issue("alu",   2'b00, 1'b0, 1'b1, 3'b000, 5'd5, 32'h0000_1234, 32'h0,        32'h0,        0, 0, 1'b0, 4'b0000, 32'h0,        0, 1'b0, 32'h0);
        issue("lb",    2'b01, 1'b0, 1'b1, 3'b000, 5'd6, 32'h0000_0103, 32'h0,        32'h80FF_FFFF, 0, 1, 1'b1, 4'b1000, 32'h0,       1, 1'b0, 32'hFFFF_FF80);
        issue("lbu",   2'b01, 1'b0, 1'b1, 3'b100, 5'd6, 32'h0000_0103, 32'h0,        32'h80FF_FFFF, 0, 1, 1'b1, 4'b1000, 32'h0,       1, 1'b0, 32'h0000_0080);
        issue("sh",    2'b00, 1'b1, 1'b0, 3'b001, 5'd0, 32'h0000_0202, 32'h0000_ABCD, 32'h0,       3, 2, 1'b1, 4'b1100, 32'hABCD_ABCD, 5, 1'b0, 32'h0);
        issue("lw_mis",2'b01, 1'b0, 1'b1, 3'b010, 5'd7, 32'h0000_0006, 32'h0,        32'h0,        0, 0, 1'b0, 4'b0000, 32'h0,        0, 1'b1, 32'h0);
        issue("lh",    2'b01, 1'b0, 1'b1, 3'b001, 5'd8, 32'h0000_0002, 32'h0,        32'h8001_0000, 0, 1, 1'b1, 4'b1100, 32'h0,       1, 1'b0, 32'hFFFF_8001);
        issue("lhu",   2'b01, 1'b0, 1'b1, 3'b101, 5'd8, 32'h0000_0002, 32'h0,        32'h8001_0000, 2, 1, 1'b1, 4'b1100, 32'h0,       3, 1'b0, 32'h0000_8001);
        issue("lh_mis",2'b01, 1'b0, 1'b1, 3'b001, 5'd8, 32'h0000_0001, 32'h0,        32'h0,        0, 0, 1'b0, 4'b0000, 32'h0,        0, 1'b1, 32'h0);
        issue("sb",    2'b00, 1'b1, 1'b0, 3'b000, 5'd0, 32'h0000_0041, 32'h1234_5678, 32'h0,       0, 1, 1'b1, 4'b0010, 32'h7878_7878, 1, 1'b0, 32'h0);
        issue("sw",    2'b00, 1'b1, 1'b0, 3'b010, 5'd0, 32'h0000_0008, 32'h1122_3344, 32'h0,       1, 3, 1'b1, 4'b1111, 32'h1122_3344, 4, 1'b0, 32'h0);

        // Reset while an access waits in RESP; the late rvalid must be ignored.
        drive(2'b01, 1'b0, 1'b1, 3'b010, 5'd3, 32'h0000_0010, 32'h0);
        dmem.gnt = 1'b1;
        #1;
        chk("rstmid_stall0", 32'(stall), 32'd1);
        @(posedge clk);
        @(negedge clk);
        dmem.gnt = 1'b0;
        #1;
        chk("rstmid_stall_resp", 32'(stall), 32'd1);
        reset = 1'b0;
        #1;
        chk("rstmid_stall_forced", 32'(stall), 32'd0);
        chk("rstmid_req_forced", 32'(dmem.req), 32'd0);
        @(posedge clk);
        @(negedge clk);
        drive(2'b00, 1'b0, 1'b0, 3'b000, 5'd0, 32'h0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset       = 1'b1;
        dmem.rvalid = 1'b1;
        dmem.rdata  = 32'hCAFE_F00D;
        #1;
        chk("rstmid_stall_after", 32'(stall), 32'd0);
        chk("rstmid_req_after", 32'(dmem.req), 32'd0);
        @(posedge clk);
        #1;
        dmem.rvalid = 1'b0;
        chk("rstmid_wb_reg_write", 32'(wb_reg_write), 32'd0);
        chk("rstmid_wb_rdata", wb_read_data, 32'h0);
        @(negedge clk);

        // Back in IDLE: a fresh load behaves normally, then a held ALU op follows the LW by one edge.
        issue("lb_post", 2'b01, 1'b0, 1'b1, 3'b000, 5'd6, 32'h0000_0103, 32'h0,     32'h80FF_FFFF, 0, 1, 1'b1, 4'b1000, 32'h0,  1, 1'b0, 32'hFFFF_FF80);
        issue("lw_b2b",  2'b01, 1'b0, 1'b1, 3'b010, 5'd4, 32'h0000_0010, 32'h0,     32'hDEAD_BEEF, 1, 1, 1'b1, 4'b1111, 32'h0,  2, 1'b0, 32'hDEAD_BEEF);
        issue("alu_b2b", 2'b00, 1'b0, 1'b1, 3'b011, 5'd9, 32'h0000_0055, 32'h0,     32'h0,         0, 0, 1'b0, 4'b0000, 32'h0,  0, 1'b0, 32'h0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage RV32I pipeline. It consumes the EX/MEM pipeline register contents and performs loads and stores over a request/grant/response data-memory bus. While an access is outstanding it stalls the front of the pipeline. It writes the MEM/WB pipeline register, including sign/zero-extended load data.

## Interface
Parameters:
- none; data and address width fixed at 32 (data_t / addr_t).

Ports:
- clk  in  1  Pipeline clock; all state updates on the rising edge.
- reset  in  1  Synchronous, active-low reset.
- ex_result_src  in  2  EX_to_MEM.ResultSrc; 2'b01 = load.
- ex_mem_write  in  1  EX_to_MEM.MemWrite; store.
- ex_reg_write  in  1  EX_to_MEM.RegWrite.
- ex_funct3  in  3  EX_to_MEM.funct3; access size and sign.
- ex_rd  in  5  EX_to_MEM.rd.
- ex_alu_result  in  32  EX_to_MEM.alu_result; byte address, or pass-through result.
- ex_write_data  in  32  Store data, unshifted rs2 value.
- ex_pc_plus4  in  32  PC+4 of the instruction.
- stall  out  1  Combinational. When 1, Execute and earlier stages must hold their registers.
- dmem_req  out  1  Request valid.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  Word-aligned address: {ex_alu_result[31:2], 2'b00}.
- dmem_be  out  4  Byte enables.
- dmem_wdata  out  32  Lane-shifted store data.
- dmem_gnt  in  1  Request accepted this cycle.
- dmem_rvalid  in  1  Response (read or write) complete this cycle.
- dmem_rdata  in  32  Read word, valid with dmem_rvalid.
- misaligned  out  1  Registered one-cycle pulse: misaligned access dropped.
- wb_reg_write, wb_result_src, wb_rd, wb_alu_result, wb_read_data, wb_pc_plus4  out  1/2/5/32/32/32  MEM_to_WB register.

## Operation
- Memory op: `mem_op = ex_mem_write | (ex_result_src == 2'b01)`.
- Size and sign from funct3:
  - 000 B (signed), 001 H (signed), 010 W, 100 BU, 101 HU.
  - Other funct3 values on a mem_op are treated as W.
- Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - No bus request is issued and stall stays 0.
  - The WB register loads a bubble: wb_reg_write=0.
  - misaligned=1 for the next cycle.
- Store lanes:
  - SB: be = 1 << addr[1:0]; wdata = {4{wd[7:0]}}.
  - SH: be = 4'b0011 << addr[1:0]; wdata = {2{wd[15:0]}}.
  - SW: be = 4'b1111; wdata = wd.
- Loads: dmem_be is the same lane mask as a store of that size.
  - Data is extracted at byte offset addr[1:0], then sign- or zero-extended per funct3.
- FSM states: IDLE, REQ, RESP.
  - IDLE:
    - If mem_op and aligned: dmem_req=1. If dmem_gnt, go to RESP; else go to REQ.
    - Otherwise stay in IDLE.
    - dmem_rvalid is ignored in IDLE.
  - REQ: dmem_req=1, outputs held from the current inputs. On dmem_gnt, go to RESP.
  - RESP: dmem_req=0. On dmem_rvalid, the access completes and the FSM returns to IDLE.
- Stall: `stall = mem_op & aligned & !(state==RESP & dmem_rvalid)`.
- MEM_to_WB register loads on every edge:
  - While stall=1 it loads a bubble: wb_reg_write=0, other fields don't-care but driven to 0.
  - Otherwise it loads ex_* fields plus wb_read_data (extended load data, or 0 for non-loads).
  - A store completing loads wb_reg_write = ex_reg_write, which the decoder sets to 0.
- Reset (reset==0):
  - State goes to IDLE, dmem_req is forced to 0 and stall to 0.
  - All wb_* outputs and misaligned become 0.
  - If reset lands mid-access, the outstanding transaction is abandoned. A later dmem_rvalid is ignored.

## Timing
- Non-memory op: zero stall cycles; ex_* values appear on wb_* after one edge.
- Memory op:
  - Stall cycles = (cycles until gnt) + (cycles from gnt to rvalid).
  - Minimum case: gnt in the op's first cycle and rvalid the next cycle gives 1 stall cycle.
  - Result is on wb_* the edge after rvalid.
- gnt and rvalid in the same cycle while in IDLE/REQ is illegal on this bus and not handled.
- Inputs are stable while stall=1 because upstream holds its registers.

## Test plan
- Reset held low 2 cycles, then ALU op (rd=5, alu_result=0x1234, reg_write=1) → stall=0; next edge wb_rd=5, wb_alu_result=0x1234, wb_reg_write=1; before that, all wb_* = 0.
- LB at addr 0x103, gnt same cycle, rvalid next with rdata=0x80FF_FFFF → dmem_be=4'b1000, dmem_addr=0x100, stall high 1 cycle, wb_read_data=0xFFFF_FF80; same with LBU → 0x0000_0080.
- SH of 0x0000_ABCD at 0x202, gnt delayed 3 cycles, rvalid 2 cycles later → dmem_be=4'b1100, wdata=0xABCD_ABCD, dmem_we=1, stall high 5 cycles, wb_reg_write=0.
- LW at 0x006 → no dmem_req, stall=0, misaligned=1 next cycle, wb_reg_write=0.
- Reset low while in RESP, rvalid arrives after reset is released → state IDLE, no WB update, stall=0.
- Back-to-back LW 0x10 then ALU op → second op is held while stall=1 and reaches wb_* exactly one edge after the load result.
